// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared opcodes, FSM state encoding and default parameters
// for the core load/store unit. Optional feature macro: CORE_LSU_FWD_EN.
package core_lsu_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_OFFS_W   = 8;
    localparam int DEF_ID_W     = 4;
    localparam int DEF_SB_DEPTH = 4;

    // Same encoding as the memory enable port.
    localparam logic [1:0] LSU_OP_NONE = 2'b00;
    localparam logic [1:0] LSU_OP_LD   = 2'b01;
    localparam logic [1:0] LSU_OP_ST   = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ST_DRAIN = 2'd1,
        LD_WAIT  = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/core_lsu_store_buffer.sv
// core_lsu_store_buffer: circular store FIFO. With CORE_LSU_FWD_EN defined it
// also searches all valid entries for an address and returns the youngest hit.
module core_lsu_store_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
`ifdef CORE_LSU_FWD_EN
    ,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              match,
    output logic [DATA_W-1:0] match_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry payload is only meaningful while counted, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

`ifdef CORE_LSU_FWD_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (addr_mem[head + PTR_W'(i)] == lookup_addr)) begin
                match      = 1'b1;
                match_data = data_mem[head + PTR_W'(i)];
            end
        end
    end
`endif

endmodule

// File: rtl/core_lsu.sv
// core_lsu: non-blocking load/store unit between the XM stage and the shared
// memory port. Stores are buffered, one load is outstanding at a time.
// Optional feature macro: CORE_LSU_FWD_EN (store-to-load forwarding).
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OFFS_W   = DEF_OFFS_W,
    parameter int ID_W     = DEF_ID_W,
    parameter int SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [1:0]             req_op,
    input  logic [ID_W+OFFS_W-1:0] req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   req_ready,
    output logic                   ld_valid,
    output logic [DATA_W-1:0]      ld_data,
    output logic                   idle,
    output logic [1:0]             mem_enable,
    output logic [ID_W+OFFS_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wr_data,
    input  logic [DATA_W-1:0]      mem_rd_data,
    input  logic                   mem_ready
);

    localparam int ADDR_W = ID_W + OFFS_W;

    lsu_state_t        state;
    logic              slot_valid;
    logic [ADDR_W-1:0] slot_addr;
    logic              sb_full;
    logic              sb_empty;
    logic [ADDR_W-1:0] sb_head_addr;
    logic [DATA_W-1:0] sb_head_data;
    logic              is_ld;
    logic              is_st;
    logic              st_accept;
    logic              ld_accept;
    logic              sb_pop;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              ld_eligible;

    assign is_ld     = (req_op == LSU_OP_LD);
    assign is_st     = (req_op == LSU_OP_ST);
    assign st_accept = req_valid && req_ready && is_st;
    assign ld_accept = req_valid && req_ready && is_ld;
    assign sb_pop    = (state == ST_DRAIN) && mem_ready;
    assign idle      = (state == IDLE) && sb_empty && !slot_valid;

    // Readiness depends only on registered occupancy, never on mem_ready.
    always_comb begin
        req_ready = 1'b1;
        if (is_st)      req_ready = !sb_full;
        else if (is_ld) req_ready = !slot_valid;
    end

`ifdef CORE_LSU_FWD_EN
    logic              sb_match;
    logic [DATA_W-1:0] sb_match_data;

    // Matching loads complete at accept; the rest never match a buffered
    // store of their own age, so the slot is always eligible.
    assign fwd_hit     = ld_accept && sb_match;
    assign fwd_data    = sb_match_data;
    assign ld_eligible = 1'b1;
`else
    assign fwd_hit     = 1'b0;
    assign fwd_data    = '0;
    assign ld_eligible = sb_empty;
`endif

    core_lsu_store_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (SB_DEPTH)
    ) u_store_buffer (
        .clk         (clk),
        .reset       (reset),
        .push        (st_accept),
        .push_addr   (req_addr),
        .push_data   (req_wdata),
        .pop         (sb_pop),
        .full        (sb_full),
        .empty       (sb_empty),
        .head_addr   (sb_head_addr),
        .head_data   (sb_head_data)
`ifdef CORE_LSU_FWD_EN
        ,
        .lookup_addr (req_addr),
        .match       (sb_match),
        .match_data  (sb_match_data)
`endif
    );

    // Memory-side FSM, load slot and registered load/memory outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            slot_valid  <= 1'b0;
            slot_addr   <= '0;
            mem_enable  <= LSU_OP_NONE;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            ld_valid    <= 1'b0;
            ld_data     <= '0;
        end else begin
            ld_valid <= 1'b0;
            if (ld_accept && !fwd_hit) begin
                slot_valid <= 1'b1;
                slot_addr  <= req_addr;
            end
            if (fwd_hit) begin
                ld_valid <= 1'b1;
                ld_data  <= fwd_data;
            end
            case (state)
                IDLE: begin
                    if (slot_valid && ld_eligible) begin
                        state      <= LD_WAIT;
                        mem_enable <= LSU_OP_LD;
                        mem_addr   <= slot_addr;
                    end else if (!sb_empty) begin
                        state       <= ST_DRAIN;
                        mem_enable  <= LSU_OP_ST;
                        mem_addr    <= sb_head_addr;
                        mem_wr_data <= sb_head_data;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        mem_enable <= LSU_OP_NONE;
                    end
                end
                LD_WAIT: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        mem_enable <= LSU_OP_NONE;
                        ld_valid   <= 1'b1;
                        ld_data    <= mem_rd_data;
                        slot_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: self-checking bench for core_lsu. The bench plays the core
// (waits for each load result before issuing more) and the memory. Expected
// load data comes from a program-order memory image; expected writes come
// from a program-order queue. Honours CORE_LSU_FWD_EN when defined.
module tb_core_lsu;
    import core_lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        idle;
    logic [1:0]  mem_enable;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;
    logic        mem_ready;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int mem_mode = 1;
    bit pulse_req = 0;
    int held = 0;
    int need = 0;
    bit stall_pend = 0;
    logic [1:0]  prev_en;
    logic [11:0] prev_addr;
    logic [7:0]  prev_data;
    int wr_done = 0;
    int rd_done = 0;
    int rd_cycles = 0;
    int rd_cyc = 0;
    int ld_cyc = 0;
    int rd_pending_wr = 0;
    logic [7:0] last_ld = 8'h00;

    logic [19:0] write_q [$];
    logic [7:0]  exp_ld_q [$];
    logic [7:0]  tb_mem [4096];
    logic [7:0]  ref_mem [4096];
    logic [7:0]  saved_mem [4096];

    core_lsu #(
        .DATA_W   (8),
        .OFFS_W   (8),
        .ID_W     (4),
        .SB_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .idle        (idle),
        .mem_enable  (mem_enable),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ready   (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: decides mem_ready on the falling edge and performs the
    // transaction that completes at the next rising edge.
    initial begin
        bit go;
        logic [19:0] w;
        mem_ready   = 1'b0;
        mem_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            mem_ready   = 1'b0;
            mem_rd_data = 8'($urandom);
            if (!reset) begin
                held       = 0;
                stall_pend = 0;
            end else if (mem_enable != LSU_OP_NONE) begin
                if (stall_pend) begin
                    checkOutput("hold_enable", 32'(mem_enable), 32'(prev_en));
                    checkOutput("hold_addr", 32'(mem_addr), 32'(prev_addr));
                    if (mem_enable == LSU_OP_ST)
                        checkOutput("hold_wdata", 32'(mem_wr_data), 32'(prev_data));
                end
                if (mem_enable == LSU_OP_LD) rd_cycles++;
                go = (mem_mode == 1) || (mem_mode == 3 && held >= 3) ||
                     (mem_mode == 2 && held >= need) || pulse_req;
                if (go) begin
                    pulse_req  = 0;
                    mem_ready  = 1'b1;
                    held       = 0;
                    stall_pend = 0;
                    need       = $urandom_range(0, 3);
                    if (mem_enable == LSU_OP_ST) begin
                        if (write_q.size() == 0) begin
                            checkOutput("unexpected_write", 32'(mem_addr), 32'hFFFF);
                        end else begin
                            w = write_q.pop_front();
                            checkOutput("write_addr", 32'(mem_addr), 32'(w[19:8]));
                            checkOutput("write_data", 32'(mem_wr_data), 32'(w[7:0]));
                        end
                        tb_mem[mem_addr] = mem_wr_data;
                        wr_done++;
                    end else if (mem_enable == LSU_OP_LD) begin
                        mem_rd_data   = tb_mem[mem_addr];
                        rd_done++;
                        rd_cyc        = cyc;
                        rd_pending_wr = write_q.size();
`ifndef CORE_LSU_FWD_EN
                        checkOutput("read_after_drain", 32'(write_q.size()), 0);
`endif
                    end else begin
                        checkOutput("enable_code", 32'(mem_enable), 32'(LSU_OP_LD));
                    end
                end else begin
                    held++;
                    stall_pend = 1;
                    prev_en    = mem_enable;
                    prev_addr  = mem_addr;
                    prev_data  = mem_wr_data;
                end
            end else if (stall_pend) begin
                checkOutput("dropped_txn", 32'(mem_enable), 32'(prev_en));
                stall_pend = 0;
            end
        end
    end

    // Load result scoreboard: every ld_valid pulse must match the oldest expected load.
    initial forever begin
        @(negedge clk);
        if (reset && ld_valid) begin
            ld_cyc  = cyc;
            last_ld = ld_data;
            if (exp_ld_q.size() == 0) checkOutput("unexpected_load", 32'(ld_data), 32'hFFFF);
            else checkOutput("load_data", 32'(ld_data), 32'(exp_ld_q.pop_front()));
        end
    end

    task automatic recordAccept();
        if (req_op == LSU_OP_ST) begin
            ref_mem[req_addr] = req_wdata;
            write_q.push_back({req_addr, req_wdata});
        end else if (req_op == LSU_OP_LD) begin
            exp_ld_q.push_back(ref_mem[req_addr]);
        end
    endtask

    task automatic waitAccept();
        bit done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            if (req_ready) begin
                @(posedge clk);
                recordAccept();
                done = 1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) checkOutput("accept_timeout", 0, 1);
        #1;
        req_valid = 1'b0;
        req_op    = LSU_OP_NONE;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr, input logic [7:0] data);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = data;
        #1;
        waitAccept();
    endtask

    task automatic waitLoad();
        int n = 0;
        while (exp_ld_q.size() != 0 && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (exp_ld_q.size() != 0) checkOutput("load_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            #2;
            if (idle && exp_ld_q.size() == 0 && write_q.size() == 0) done = 1;
        end
        if (!done) checkOutput("idle_timeout", 0, 1);
    endtask

    initial begin
        int rd0;
        int wr0;
        logic [11:0] a;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = LSU_OP_NONE;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_mem_enable", 32'(mem_enable), 0);
        checkOutput("rst_ld_valid", 32'(ld_valid), 0);
        checkOutput("rst_ld_data", 32'(ld_data), 0);
        checkOutput("rst_idle", 32'(idle), 1);
        checkOutput("rst_req_ready", 32'(req_ready), 1);
        req_op = LSU_OP_ST;
        #1 checkOutput("rst_ready_st", 32'(req_ready), 1);
        req_op = LSU_OP_LD;
        #1 checkOutput("rst_ready_ld", 32'(req_ready), 1);
        req_op = LSU_OP_NONE;
        @(negedge clk);
        #2 reset = 1'b1;

        // Full buffer back-pressure and single-pulse drain
        mem_mode = 0;
        applyStimulus(LSU_OP_ST, 12'h012, 8'hA5);
        for (int i = 1; i < 4; i++) applyStimulus(LSU_OP_ST, 12'h012 + 12'(i), 8'($urandom));
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = LSU_OP_ST;
        req_addr  = 12'h01F;
        req_wdata = 8'h5A;
        #1;
        checkOutput("full_ready", 32'(req_ready), 0);
        checkOutput("drain_enable", 32'(mem_enable), 32'(LSU_OP_ST));
        checkOutput("drain_addr", 32'(mem_addr), 32'h012);
        checkOutput("drain_data", 32'(mem_wr_data), 32'hA5);
        pulse_req = 1;
        @(negedge clk);
        #1 checkOutput("still_full", 32'(req_ready), 0);
        @(negedge clk);
        #1 checkOutput("ready_after_pop", 32'(req_ready), 1);
        checkOutput("one_write", 32'(wr_done), 1);
        waitAccept();
        mem_mode = 1;
        waitIdle();

        // Two stores to one address followed by a load of it
        mem_mode = 0;
        rd0 = rd_done;
        wr0 = rd_cycles;
        applyStimulus(LSU_OP_ST, 12'h105, 8'h3C);
        applyStimulus(LSU_OP_ST, 12'h105, 8'h7E);
        applyStimulus(LSU_OP_LD, 12'h105, 8'h00);
        @(negedge clk);
        #2;
`ifdef CORE_LSU_FWD_EN
        checkOutput("fwd_ld_valid", 32'(ld_valid), 1);
        checkOutput("fwd_ld_data", 32'(ld_data), 32'h7E);
        repeat (3) @(negedge clk);
        #2 checkOutput("fwd_no_read", 32'(rd_cycles - wr0), 0);
        mem_mode = 1;
`else
        checkOutput("nofwd_ld_waits", 32'(ld_valid), 0);
        mem_mode = 1;
        waitLoad();
        checkOutput("nofwd_ld_data", 32'(last_ld), 32'h7E);
        checkOutput("nofwd_one_read", 32'(rd_done - rd0), 1);
`endif
        waitIdle();

        // Load arriving behind a slow drain
        mem_mode = 3;
        applyStimulus(LSU_OP_ST, 12'h030, 8'($urandom));
        applyStimulus(LSU_OP_LD, 12'h020, 8'h00);
        waitLoad();
        checkOutput("write_before_read", 32'(rd_pending_wr), 0);
        checkOutput("ld_after_mem_ready", 32'(ld_cyc - rd_cyc), 1);
        waitIdle();

        // Reset while draining with three entries queued
        mem_mode  = 0;
        saved_mem = ref_mem;
        for (int i = 0; i < 3; i++) applyStimulus(LSU_OP_ST, 12'h040 + 12'(i), 8'($urandom));
        repeat (2) @(negedge clk);
        #1 checkOutput("drain_before_reset", 32'(mem_enable), 32'(LSU_OP_ST));
        #1 reset = 1'b0;
        #1;
        checkOutput("reset_mem_enable", 32'(mem_enable), 0);
        checkOutput("reset_idle", 32'(idle), 1);
        checkOutput("reset_ld_valid", 32'(ld_valid), 0);
        ref_mem = saved_mem;
        write_q.delete();
        wr0 = wr_done;
        @(negedge clk);
        #2 reset = 1'b1;
        mem_mode = 1;
        repeat (10) @(negedge clk);
        #2;
        checkOutput("no_write_after_reset", 32'(wr_done - wr0), 0);
        checkOutput("idle_after_reset", 32'(idle), 1);
        applyStimulus(LSU_OP_LD, 12'h040, 8'h00);
        waitLoad();

        // Tail wrap-around with random memory latency
        mem_mode = 2;
        for (int i = 0; i < 10; i++) applyStimulus(LSU_OP_ST, 12'h100 + 12'(i % 8), 8'($urandom));
        waitIdle();

        // Random mix of loads and stores on a small address pool
        for (int i = 0; i < 150; i++) begin
            a = 12'h100 + 12'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 6) begin
                applyStimulus(LSU_OP_ST, a, 8'($urandom));
            end else begin
                applyStimulus(LSU_OP_LD, a, 8'h00);
                waitLoad();
            end
        end
        mem_mode = 1;
        waitIdle();
        for (int i = 0; i < 8; i++)
            checkOutput("final_mem", 32'(tb_mem[12'h100 + 12'(i)]), 32'(ref_mem[12'h100 + 12'(i)]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
